yv12_fetch_ctrl: RTL and testbench

YV12_FETCH_CTRL -- requirements
Module: yv12_fetch_ctrl

---
 rtl/yv12_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_yv12_fetch_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/yv12_fetch_ctrl.sv
// yv12_fetch_ctrl: walks a planar YV12 frame in raster pixel pairs, reading V, U, Y0, Y1 per pair
// and presenting one full YUV pixel per data_valid strobe.
module yv12_fetch_ctrl #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 17,
  parameter int Y_BASE     = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rd_data_i,
  output logic              data_valid_o,
  output logic [7:0]        y_data_o,
  output logic [7:0]        u_data_o,
  output logic [7:0]        v_data_o,
  output logic [9:0]        pixel_x_o,
  output logic [9:0]        pixel_y_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [2:0] IDLE = 3'd0, FETCH_V = 3'd1, FETCH_U = 3'd2,
                         FETCH_Y0 = 3'd3, FETCH_Y1 = 3'd4, FLUSH = 3'd5;
  localparam logic [ADDR_W-1:0] YB = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] VB = ADDR_W'(Y_BASE + IMG_WIDTH * IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] UB = ADDR_W'(Y_BASE + IMG_WIDTH * IMG_HEIGHT + IMG_WIDTH * IMG_HEIGHT / 4);
  logic [2:0]        state_q, state_d, prev_q;
  logic [9:0]        col_q, col_d, row_q, row_d;
  logic [7:0]        v_stage_q, u_stage_q, y_q, u_q, v_q;
  logic [9:0]        px_q, py_q;
  logic              dv_q, busy_q, done_q, row_end, last_pair;
  logic [ADDR_W-1:0] y_addr, c_idx;
  assign row_end   = col_q == 10'(IMG_WIDTH - 2);
  assign last_pair = row_end && row_q == 10'(IMG_HEIGHT - 1);
  assign y_addr = YB + ADDR_W'(row_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_q);
  assign c_idx  = ADDR_W'(row_q >> 1) * ADDR_W'(IMG_WIDTH / 2) + ADDR_W'(col_q >> 1);
  assign mem_rd_en_o = state_q inside {FETCH_V, FETCH_U, FETCH_Y0, FETCH_Y1};
  assign mem_addr_o  = state_q == FETCH_V  ? VB + c_idx :
                       state_q == FETCH_U  ? UB + c_idx :
                       state_q == FETCH_Y0 ? y_addr :
                       state_q == FETCH_Y1 ? y_addr + ADDR_W'(1) : '0;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE:     state_d = start_i ? FETCH_V : IDLE;
      FETCH_V:  state_d = FETCH_U;
      FETCH_U:  state_d = FETCH_Y0;
      FETCH_Y0: state_d = FETCH_Y1;
      FETCH_Y1: begin
        state_d = last_pair ? FLUSH : FETCH_V;
        col_d   = row_end ? 10'd0 : col_q + 10'd2;
        row_d   = last_pair ? 10'd0 : row_end ? row_q + 10'd1 : row_q;
      end
      default:  state_d = IDLE;
    endcase
  end
  // prev_q tags the data returning this cycle with the state that requested it
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      prev_q    <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      v_stage_q <= '0;
      u_stage_q <= '0;
      y_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      px_q      <= '0;
      py_q      <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_q == FLUSH;
      dv_q    <= prev_q == FETCH_Y0 || prev_q == FETCH_Y1;
      if (prev_q == FETCH_V) v_stage_q <= mem_rd_data_i;
      if (prev_q == FETCH_U) u_stage_q <= mem_rd_data_i;
      if (prev_q == FETCH_Y0) begin
        y_q  <= mem_rd_data_i;
        u_q  <= u_stage_q;
        v_q  <= v_stage_q;
        px_q <= col_q;
        py_q <= row_q;
      end
      if (prev_q == FETCH_Y1) begin
        y_q  <= mem_rd_data_i;
        px_q <= px_q + 10'd1;
      end
    end
  end
  assign data_valid_o = dv_q;
  assign y_data_o     = y_q;
  assign u_data_o     = u_q;
  assign v_data_o     = v_q;
  assign pixel_x_o    = px_q;
  assign pixel_y_o    = py_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_yv12_fetch_ctrl.sv
// tb_yv12_fetch_ctrl: scoreboard bench for a 4x2 frame; memory returns its own address as data.
module tb_yv12_fetch_ctrl;
  localparam int W = 4, H = 2, AW = 17, YB = 0;
  localparam int VB = YB + W * H, UB = VB + W * H / 4;
  typedef struct packed {
    logic [7:0] y, u, v;
    logic [9:0] x, r;
  } pix_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic rd_en, dv, busy, done;
  logic [AW-1:0] addr;
  logic [7:0] rd_data = 8'h00, y_d, u_d, v_d;
  logic [9:0] px, py;
  pix_t exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  int pass_cnt = 0, total_cnt = 0;

  yv12_fetch_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .Y_BASE(YB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mem_rd_en_o(rd_en), .mem_addr_o(addr),
    .mem_rd_data_i(rd_data), .data_valid_o(dv), .y_data_o(y_d), .u_data_o(u_d), .v_data_o(v_d),
    .pixel_x_o(px), .pixel_y_o(py), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;
  // garbage on idle cycles exposes any capture on the wrong cycle
  always @(posedge clk) rd_data <= rd_en ? addr[7:0] : 8'($urandom);

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2) begin
        int ci = (r / 2) * (W / 2) + c / 2;
        exp_addr.push_back(AW'(VB + ci));
        exp_addr.push_back(AW'(UB + ci));
        exp_addr.push_back(AW'(YB + r * W + c));
        exp_addr.push_back(AW'(YB + r * W + c + 1));
        for (int k = 0; k < 2; k++)
          exp_pix.push_back('{y: 8'(YB + r * W + c + k), u: 8'(UB + ci), v: 8'(VB + ci),
                              x: 10'(c + k), r: 10'(r)});
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rd_en, addr, dv, y_d, u_d, v_d, px, py, busy, done} !== '0)
      $display("FAIL reset_outputs got %h want 0", {rd_en, addr, dv, y_d, u_d, v_d, px, py, busy, done});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if ({rd_en, busy, dv, done} !== 4'b0) $display("FAIL idle_hold got %b want 0000", {rd_en, busy, dv, done});
      else pass_cnt++;
    end
  endtask

  // Starts a frame at the next edge (unless start is already high from a chained frame).
  // Start is held high during cycles hold_lo..hold_hi; abort_at>0 asserts reset at the edge ending that cycle.
  task automatic run_frame(input int hold_lo, input int hold_hi, input bit chain_next, input int abort_at);
    int last_n;
    pix_t got, want;
    push_frame();
    if (!start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    last_n = abort_at > 0 ? 20 : 18;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (abort_at > 0 && n > abort_at) begin
        total_cnt++;
        if ({rd_en, addr, dv, y_d, u_d, v_d, px, py, busy, done} !== '0)
          $display("FAIL abort_quiet cyc %0d got %h want 0", n, {rd_en, addr, dv, y_d, u_d, v_d, px, py, busy, done});
        else pass_cnt++;
      end else begin
        bit exp_en, exp_dv;
        exp_en = n <= 16;
        exp_dv = n >= 5 && ((n - 5) % 4) < 2;
        total_cnt++;
        if (rd_en !== exp_en) $display("FAIL rd_en cyc %0d got %b want %b", n, rd_en, exp_en);
        else pass_cnt++;
        if (exp_en && exp_addr.size() > 0) begin
          logic [AW-1:0] a;
          a = exp_addr.pop_front();
          total_cnt++;
          if (addr !== a) $display("FAIL mem_addr cyc %0d got %0d want %0d", n, addr, a);
          else pass_cnt++;
        end
        total_cnt++;
        if (dv !== exp_dv) $display("FAIL data_valid cyc %0d got %b want %b", n, dv, exp_dv);
        else pass_cnt++;
        if (exp_dv && exp_pix.size() > 0) begin
          want = exp_pix.pop_front();
          got = '{y: y_d, u: u_d, v: v_d, x: px, r: py};
          total_cnt++;
          if (got !== want)
            $display("FAIL pixel cyc %0d got y%0d u%0d v%0d x%0d r%0d want y%0d u%0d v%0d x%0d r%0d", n,
                     got.y, got.u, got.v, got.x, got.r, want.y, want.u, want.v, want.x, want.r);
          else pass_cnt++;
        end
        total_cnt++;
        if ({done, busy} !== {n == 18, n <= 17})
          $display("FAIL done_busy cyc %0d got %b%b want %b%b", n, done, busy, n == 18, n <= 17);
        else pass_cnt++;
      end
      start = (n >= hold_lo && n <= hold_hi) || (chain_next && n == 18);
      if (n == abort_at) rst_n = 1'b0;
    end
    if (abort_at > 0) begin
      exp_addr.delete();
      exp_pix.delete();
      rst_n = 1'b1;
    end else begin
      total_cnt++;
      if (exp_addr.size() + exp_pix.size() != 0)
        $display("FAIL scoreboard_drain got %0d left want 0", exp_addr.size() + exp_pix.size());
      else pass_cnt++;
    end
    if (!chain_next) begin
      @(negedge clk);
      total_cnt++;
      if ({rd_en, busy, dv, done} !== 4'b0) $display("FAIL post_idle got %b want 0000", {rd_en, busy, dv, done});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame();
    run_frame(0, 0, 1'b0, 0);
  endtask

  task automatic test_start_while_busy();
    run_frame(3, 10, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 1'b1, 0);
    run_frame(0, 0, 1'b0, 0);
  endtask

  task automatic test_abort();
    run_frame(0, 0, 1'b0, 7);
    run_frame(0, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
